// File: rtl/majority_rr_sched.sv
// majority_rr_sched
//   Shares one popcount / majority-compare datapath among NREQ requesters.
//   A round-robin arbiter grants at most one vote word per cycle; the
//   popcount, the detect flag and the winning requester ID are captured in
//   a one-entry output register with valid/ready handshake. Two saturating
//   counters track accepted words and accepted words that raised detect.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   req_valid    per-requester valid
//   req_data     packed vote words, word i at req_data[i*DW +: DW]
//   req_ready    one-hot grant (word i accepted when valid & ready)
//   res_valid    output register holds a result
//   res_ready    downstream takes the result when valid & ready
//   res_detect   popcount >= THRESH
//   res_count    popcount of the granted word
//   res_id       index of the requester that supplied the word
//   stat_votes   saturating count of accepted words
//   stat_detects saturating count of accepted words with detect set

module majority_rr_sched #(
  parameter int NREQ   = 4,
  parameter int DW     = 8,
  parameter int THRESH = DW / 2,
  parameter int CNTW   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DW-1:0]        req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_detect,
  output logic [$clog2(DW+1)-1:0]   res_count,
  output logic [$clog2(NREQ)-1:0]   res_id,
  output logic [CNTW-1:0]           stat_votes,
  output logic [CNTW-1:0]           stat_detects
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(DW + 1);
  localparam int P2  = 1 << $clog2(DW);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] winner;
  logic           found;
  logic           can_acc;
  logic           accept;
  logic [DW-1:0]  sel_word;
  logic [CW-1:0]  sel_count;
  logic           sel_detect;

  // Adder tree over the word padded to a power of two. Every node is CW
  // bits wide, so partial sums are zero-extended and no carry is dropped.
  // The in-place update is safe because node i is written only after
  // nodes 2i and 2i+1 have been read.
  function automatic logic [CW-1:0] popcount(input logic [DW-1:0] w);
    logic [P2-1:0] wp;
    logic [CW-1:0] s [P2];
    wp = '0;
    wp[DW-1:0] = w;
    for (int i = 0; i < P2; i++) s[i] = CW'(wp[i]);
    for (int span = P2 / 2; span >= 1; span = span / 2)
      for (int i = 0; i < span; i++) s[i] = s[2*i] + s[2*i+1];
    return s[0];
  endfunction

  // The register can take a new result when it is empty or being drained.
  assign can_acc = !res_valid || res_ready;

  // Round-robin search starting at ptr and wrapping; the first valid wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
        found  = 1'b1;
        winner = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  // Grant is suppressed during reset and whenever the result is stuck.
  always_comb begin
    req_ready = '0;
    if (rst_n && can_acc && found) req_ready[winner] = 1'b1;
  end

  assign accept     = rst_n && can_acc && found;
  assign sel_word   = req_data[int'(winner)*DW +: DW];
  assign sel_count  = popcount(sel_word);
  assign sel_detect = (32'(sel_count) >= 32'(THRESH));

  // Result register, round-robin pointer and statistics. A drain with a
  // simultaneous accept simply reloads, so the result stream has no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid    <= 1'b0;
      res_detect   <= 1'b0;
      res_count    <= '0;
      res_id       <= '0;
      ptr          <= '0;
      stat_votes   <= '0;
      stat_detects <= '0;
    end else begin
      if (accept) begin
        res_valid  <= 1'b1;
        res_count  <= sel_count;
        res_detect <= sel_detect;
        res_id     <= winner;
        ptr        <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
        if (stat_votes != '1) stat_votes <= stat_votes + 1'b1;
        if (sel_detect && (stat_detects != '1)) stat_detects <= stat_detects + 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_majority_rr_sched.sv
// tb_majority_rr_sched
//   Self-checking bench for majority_rr_sched. A reference model tracks the
//   round-robin pointer, output-register occupancy and statistics; expected
//   results are queued at accept time and compared when the DUT drains them.

module tb_majority_rr_sched;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  typedef struct {
    int id;
    int count;
    int detect;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic                 res_detect;
  logic [3:0]           res_count;
  logic [1:0]           res_id;
  logic [15:0]          stat_votes;
  logic [15:0]          stat_detects;

  int   assertion_count;
  int   fail_count;
  exp_t sb_q[$];
  int   m_ptr;
  int   m_votes;
  int   m_detects;
  bit   m_res_valid;
  bit   one_shot;

  majority_rr_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_detect   (res_detect),
    .res_count    (res_count),
    .res_id       (res_id),
    .stat_votes   (stat_votes),
    .stat_detects (stat_detects)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertion_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    m_ptr       = 0;
    m_votes     = 0;
    m_detects   = 0;
    m_res_valid = 0;
    sb_q.delete();
  endtask

  // Present a word on requester i.
  task automatic applyStimulus(input int i, input logic [DW-1:0] word);
    req_valid[i]            = 1'b1;
    req_data[i*DW +: DW]    = word;
  endtask

  // One clock cycle: check grant and result before the edge, update the
  // model, then check statistics and update requesters after the edge.
  task automatic stepCycle();
    logic [NREQ-1:0] exp_ready;
    logic [DW-1:0]   w;
    bit              any;
    bit              can;
    int              win;
    exp_t            e;
    exp_t            got;
    @(negedge clk);
    exp_ready = '0;
    any       = 0;
    win       = 0;
    can       = !m_res_valid || res_ready;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && req_valid[(m_ptr + k) % NREQ]) begin
        any = 1;
        win = (m_ptr + k) % NREQ;
      end
    end
    if (any && can && rst_n) exp_ready[win] = 1'b1;
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    checkOutput("res_valid", 32'(res_valid), 32'(m_res_valid));
    if (m_res_valid && res_ready && rst_n) begin
      if (sb_q.size() == 0) begin
        checkOutput("sb_empty", 32'd1, 32'd0);
      end else begin
        got = sb_q.pop_front();
        checkOutput("res_id", 32'(res_id), 32'(got.id));
        checkOutput("res_count", 32'(res_count), 32'(got.count));
        checkOutput("res_detect", 32'(res_detect), 32'(got.detect));
      end
    end
    if (!rst_n) begin
      modelReset();
    end else if (exp_ready != '0) begin
      w        = req_data[win*DW +: DW];
      e.id     = win;
      e.count  = $countones(w);
      e.detect = (e.count >= DW / 2) ? 1 : 0;
      sb_q.push_back(e);
      m_ptr = (win + 1) % NREQ;
      if (m_votes < 65535) m_votes++;
      if (e.detect == 1 && m_detects < 65535) m_detects++;
      m_res_valid = 1;
    end else if (m_res_valid && res_ready) begin
      m_res_valid = 0;
    end
    @(posedge clk);
    #1;
    checkOutput("stat_votes", 32'(stat_votes), 32'(m_votes));
    checkOutput("stat_detects", 32'(stat_detects), 32'(m_detects));
    if (exp_ready != '0) begin
      if (one_shot) req_valid[win] = 1'b0;
      else req_data[win*DW +: DW] = DW'($urandom);
    end
  endtask

  // Reset with inputs idle; the DUT register state must be all zero after.
  task automatic resetDut();
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_count", 32'(res_count), 32'd0);
    checkOutput("rst_res_id", 32'(res_id), 32'd0);
    checkOutput("rst_res_detect", 32'(res_detect), 32'd0);
    checkOutput("rst_stat_votes", 32'(stat_votes), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] words [4];
    assertion_count = 0;
    fail_count      = 0;
    rst_n           = 1'b0;
    req_valid       = '0;
    req_data        = '0;
    res_ready       = 1'b1;
    one_shot        = 1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;

    // Single request from requester 0 with 0x0F.
    resetDut();
    applyStimulus(0, 8'h0F);
    stepCycle();
    stepCycle();
    checkOutput("t1_count", 32'(res_count), 32'd4);
    checkOutput("t1_id", 32'(res_id), 32'd0);

    // All requesters continuously valid: strict rotation.
    resetDut();
    one_shot = 0;
    for (int i = 0; i < NREQ; i++) applyStimulus(i, DW'($urandom));
    repeat (8) stepCycle();
    checkOutput("t2_votes", 32'(stat_votes), 32'd8);
    one_shot  = 1;
    req_valid = '0;
    stepCycle();

    // Backpressure holds the result and withholds the grant.
    resetDut();
    applyStimulus(0, 8'h3C);
    stepCycle();
    res_ready = 1'b0;
    applyStimulus(2, 8'hF0);
    repeat (3) stepCycle();
    checkOutput("t3_hold_id", 32'(res_id), 32'd0);
    checkOutput("t3_hold_count", 32'(res_count), 32'd4);
    res_ready = 1'b1;
    stepCycle();
    checkOutput("t3_no_bubble", 32'(res_valid), 32'd1);
    checkOutput("t3_new_id", 32'(res_id), 32'd2);
    stepCycle();
    stepCycle();

    // Datapath boundaries: all-zero, below, at and above threshold.
    resetDut();
    words[0] = 8'h00;
    words[1] = 8'h07;
    words[2] = 8'h17;
    words[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, words[i]);
      stepCycle();
    end
    stepCycle();
    checkOutput("t4_detects", 32'(stat_detects), 32'd2);
    checkOutput("t4_last_count", 32'(res_count), 32'd8);

    // Pointer wrap from 3 to 0.
    resetDut();
    applyStimulus(2, 8'h01);
    stepCycle();
    applyStimulus(1, 8'h11);
    applyStimulus(3, 8'h33);
    stepCycle();
    checkOutput("t5_first_id", 32'(res_id), 32'd3);
    stepCycle();
    checkOutput("t5_second_id", 32'(res_id), 32'd1);
    stepCycle();

    // Reset mid-operation with a held result and ptr=2.
    resetDut();
    res_ready = 1'b0;
    applyStimulus(1, 8'hAA);
    stepCycle();
    stepCycle();
    rst_n = 1'b0;
    stepCycle();
    rst_n     = 1'b1;
    res_ready = 1'b1;
    checkOutput("t6_res_valid", 32'(res_valid), 32'd0);
    checkOutput("t6_votes", 32'(stat_votes), 32'd0);
    applyStimulus(1, 8'h01);
    applyStimulus(3, 8'h03);
    stepCycle();
    checkOutput("t6_restart_id", 32'(res_id), 32'd1);
    stepCycle();
    stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertion_count, fail_count);
    $finish;
  end

endmodule
